// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache controller.
// Signal suffixes are from the controller's point of view (slave modport).
interface icache_ctrl_if #(
    parameter int ADDR_W    = 64,
    parameter int MEM_TAG_W = 4
);
    // fetch side
    logic                 if_req_vld_i;
    logic [ADDR_W-1:0]    if_req_addr_i;
    logic                 if_flush_i;
    logic                 icache_vld_o;
    logic [63:0]          icache_data_o;
    logic                 icache_busy_o;
    // memory side
    logic [MEM_TAG_W-1:0] mem2ic_response_i;
    logic [63:0]          mem2ic_data_i;
    logic [MEM_TAG_W-1:0] mem2ic_tag_i;
    logic [1:0]           ic2mem_command_o;
    logic [ADDR_W-1:0]    ic2mem_addr_o;
    // statistics
    logic [31:0]          ic_hit_cnt_o;
    logic [31:0]          ic_miss_cnt_o;

    modport slave (
        input  if_req_vld_i, if_req_addr_i, if_flush_i,
        input  mem2ic_response_i, mem2ic_data_i, mem2ic_tag_i,
        output icache_vld_o, icache_data_o, icache_busy_o,
        output ic2mem_command_o, ic2mem_addr_o,
        output ic_hit_cnt_o, ic_miss_cnt_o
    );

    modport master (
        output if_req_vld_i, if_req_addr_i, if_flush_i,
        output mem2ic_response_i, mem2ic_data_i, mem2ic_tag_i,
        input  icache_vld_o, icache_data_o, icache_busy_o,
        input  ic2mem_command_o, ic2mem_addr_o,
        input  ic_hit_cnt_o, ic_miss_cnt_o
    );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped blocking instruction cache controller: one 64-bit word per line,
// combinational hits, and a single outstanding tagged BUS_LOAD on a miss.
module icache_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int LINES     = 32,
    parameter int IDX_W     = 5,
    parameter int MEM_TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    icache_ctrl_if.slave   bus
);
    localparam int         TAG_W    = ADDR_W - IDX_W - 3;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    miss_addr_q, miss_addr_d;
    logic [MEM_TAG_W-1:0] pend_tag_q, pend_tag_d;
    logic [31:0]          hit_cnt_q, miss_cnt_q;

    logic [LINES-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [63:0]          data_q [LINES];

    logic [IDX_W-1:0]     req_idx, fill_idx;
    logic [TAG_W-1:0]     req_tag, fill_tag;
    logic                 hit, miss_start, fill_en;
    logic [1:0]           cmd;
    logic [ADDR_W-1:0]    mem_addr;
    logic [2:0]           unused_offset;

    assign req_idx       = bus.if_req_addr_i[IDX_W+2:3];
    assign req_tag       = bus.if_req_addr_i[ADDR_W-1:IDX_W+3];
    assign fill_idx      = miss_addr_q[IDX_W+2:3];
    assign fill_tag      = miss_addr_q[ADDR_W-1:IDX_W+3];
    assign unused_offset = bus.if_req_addr_i[2:0];

    // Zero-latency hit, served in every state; suppressed while reset is held.
    assign hit = !rst && bus.if_req_vld_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign bus.icache_vld_o     = hit;
    assign bus.icache_data_o    = hit ? data_q[req_idx] : 64'd0;
    assign bus.icache_busy_o    = (state_q != S_IDLE);
    assign bus.ic2mem_command_o = cmd;
    assign bus.ic2mem_addr_o    = mem_addr;
    assign bus.ic_hit_cnt_o     = hit_cnt_q;
    assign bus.ic_miss_cnt_o    = miss_cnt_q;

    // Miss FSM: next state, memory command and fill strobe.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        pend_tag_d  = pend_tag_q;
        cmd         = BUS_NONE;
        mem_addr    = '0;
        miss_start  = 1'b0;
        fill_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.if_req_vld_i && !hit && !bus.if_flush_i) begin
                    miss_addr_d = {bus.if_req_addr_i[ADDR_W-1:3], 3'b000};
                    miss_start  = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                cmd      = BUS_LOAD;
                mem_addr = miss_addr_q;
                // An accepted request is in flight, so a flush cannot cancel it.
                if (bus.mem2ic_response_i != '0) begin
                    pend_tag_d = bus.mem2ic_response_i;
                    state_d    = S_WAIT;
                end else if (bus.if_flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (pend_tag_q != '0 && bus.mem2ic_tag_i == pend_tag_q) begin
                    fill_en    = 1'b1;
                    pend_tag_d = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, valid bits and statistics; reset drops any outstanding miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            pend_tag_q  <= '0;
            valid_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            pend_tag_q  <= pend_tag_d;
            hit_cnt_q   <= hit_cnt_q + 32'(hit);
            miss_cnt_q  <= miss_cnt_q + 32'(miss_start);
            if (fill_en) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Line tag/data storage; a fill overwrites whatever the line held.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.mem2ic_data_i;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed testbench for icache_ctrl: cold miss, retry, flush, conflict
// eviction, hit under miss, stray tags and reset during an outstanding miss.
module tb_icache_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   exp_hits;

    icache_ctrl_if #(.ADDR_W(64), .MEM_TAG_W(4)) bus ();

    icache_ctrl #(.ADDR_W(64), .LINES(32), .IDX_W(5), .MEM_TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        exp_hits = 0;
        rst                   = 1'b1;
        bus.if_req_vld_i      = 1'b0;
        bus.if_req_addr_i     = '0;
        bus.if_flush_i        = 1'b0;
        bus.mem2ic_response_i = '0;
        bus.mem2ic_data_i     = '0;
        bus.mem2ic_tag_i      = '0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check_eq("rst_vld",  64'(bus.icache_vld_o), 64'd0);
        check_eq("rst_data", bus.icache_data_o, 64'd0);
        check_eq("rst_cmd",  64'(bus.ic2mem_command_o), 64'd0);
        check_eq("rst_addr", bus.ic2mem_addr_o, 64'd0);
        check_eq("rst_busy", 64'(bus.icache_busy_o), 64'd0);
        check_eq("rst_hits", 64'(bus.ic_hit_cnt_o), 64'd0);
        check_eq("rst_miss", 64'(bus.ic_miss_cnt_o), 64'd0);

        // cold miss at 0x100, accepted with tag 3
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h100; #1;
        check_eq("cold_vld", 64'(bus.icache_vld_o), 64'd0);
        check_eq("cold_cmd_idle", 64'(bus.ic2mem_command_o), 64'd0);
        step();
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("cold_cmd", 64'(bus.ic2mem_command_o), 64'd1);
        check_eq("cold_addr", bus.ic2mem_addr_o, 64'h100);
        check_eq("cold_busy", 64'(bus.icache_busy_o), 64'd1);
        check_eq("cold_miss", 64'(bus.ic_miss_cnt_o), 64'd1);
        bus.mem2ic_response_i = 4'd3; bus.mem2ic_tag_i = 4'd3; bus.mem2ic_data_i = 64'h1;
        step();
        bus.mem2ic_response_i = '0; bus.mem2ic_tag_i = '0; #1;
        check_eq("same_cycle_tag_nofill", 64'(bus.icache_busy_o), 64'd1);
        check_eq("wait_cmd", 64'(bus.ic2mem_command_o), 64'd0);
        check_eq("wait_addr", bus.ic2mem_addr_o, 64'd0);
        repeat (4) step();
        bus.mem2ic_tag_i = 4'd3; bus.mem2ic_data_i = 64'hDEADBEEF_01234567;
        step();
        bus.mem2ic_tag_i = '0; #1;
        check_eq("cold_fill_idle", 64'(bus.icache_busy_o), 64'd0);
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h100; #1;
        check_eq("cold_hit_vld", 64'(bus.icache_vld_o), 64'd1);
        check_eq("cold_hit_data", bus.icache_data_o, 64'hDEADBEEF_01234567);
        step(); exp_hits++;
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("cold_hitcnt", 64'(bus.ic_hit_cnt_o), 64'(exp_hits));
        check_eq("cold_misscnt", 64'(bus.ic_miss_cnt_o), 64'd1);

        // rejection retry at 0x108: three rejects then tag 5
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h108; #1;
        check_eq("retry_vld", 64'(bus.icache_vld_o), 64'd0);
        step();
        bus.if_req_vld_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.mem2ic_response_i = (i == 3) ? 4'd5 : 4'd0; #1;
            check_eq("retry_cmd", 64'(bus.ic2mem_command_o), 64'd1);
            check_eq("retry_addr", bus.ic2mem_addr_o, 64'h108);
            step();
        end
        bus.mem2ic_response_i = '0; #1;
        check_eq("retry_wait_busy", 64'(bus.icache_busy_o), 64'd1);
        bus.mem2ic_tag_i = 4'd5; bus.mem2ic_data_i = 64'h1111_2222_3333_4444;
        step();
        bus.mem2ic_tag_i = '0;
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h108; #1;
        check_eq("retry_hit_data", bus.icache_data_o, 64'h1111_2222_3333_4444);
        step(); exp_hits++;
        bus.if_req_vld_i = 1'b0;

        // flush in REQ with no acceptance cancels the miss
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h110;
        step();
        bus.if_req_vld_i = 1'b0; bus.if_flush_i = 1'b1; #1;
        check_eq("flush_req_cmd", 64'(bus.ic2mem_command_o), 64'd1);
        step();
        bus.if_flush_i = 1'b0; #1;
        check_eq("flush_cmd", 64'(bus.ic2mem_command_o), 64'd0);
        check_eq("flush_busy", 64'(bus.icache_busy_o), 64'd0);
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h110; #1;
        check_eq("flush_nofill", 64'(bus.icache_vld_o), 64'd0);
        step();
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("flush_remiss", 64'(bus.ic_miss_cnt_o), 64'd4);
        bus.mem2ic_response_i = 4'd6;
        step();
        bus.mem2ic_response_i = '0;
        // flush during WAIT does not stop the fill
        bus.mem2ic_tag_i = 4'd6; bus.mem2ic_data_i = 64'h5555_6666_7777_8888; bus.if_flush_i = 1'b1;
        step();
        bus.mem2ic_tag_i = '0; bus.if_flush_i = 1'b0;
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h110; #1;
        check_eq("wait_flush_fill", bus.icache_data_o, 64'h5555_6666_7777_8888);
        step(); exp_hits++;
        bus.if_req_vld_i = 1'b0;

        // conflict: 0x200 shares index 0 with 0x100
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h200; #1;
        check_eq("conf_vld", 64'(bus.icache_vld_o), 64'd0);
        step();
        bus.if_req_vld_i = 1'b0; bus.mem2ic_response_i = 4'd2;
        step();
        bus.mem2ic_response_i = '0; bus.mem2ic_tag_i = 4'd2; bus.mem2ic_data_i = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        bus.mem2ic_tag_i = '0;
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h200; #1;
        check_eq("conf_hit_data", bus.icache_data_o, 64'hAAAA_BBBB_CCCC_DDDD);
        step(); exp_hits++;
        bus.if_req_addr_i = 64'h100; #1;
        check_eq("evicted_vld", 64'(bus.icache_vld_o), 64'd0);
        step();
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("evict_miss", 64'(bus.ic_miss_cnt_o), 64'd6);
        bus.mem2ic_response_i = 4'd4;
        step();
        bus.mem2ic_response_i = '0;

        // hit under miss, then a stray tag
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h108; #1;
        check_eq("hum_vld", 64'(bus.icache_vld_o), 64'd1);
        check_eq("hum_data", bus.icache_data_o, 64'h1111_2222_3333_4444);
        check_eq("hum_busy", 64'(bus.icache_busy_o), 64'd1);
        step(); exp_hits++;
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("hum_hitcnt", 64'(bus.ic_hit_cnt_o), 64'(exp_hits));
        bus.mem2ic_tag_i = 4'd7; bus.mem2ic_data_i = 64'h0BAD;
        step();
        bus.mem2ic_tag_i = '0; #1;
        check_eq("stray_tag_ignored", 64'(bus.icache_busy_o), 64'd1);
        bus.mem2ic_tag_i = 4'd4; bus.mem2ic_data_i = 64'hCAFE_F00D_1234_5678;
        step();
        bus.mem2ic_tag_i = '0;
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h100; #1;
        check_eq("refill_data", bus.icache_data_o, 64'hCAFE_F00D_1234_5678);
        step(); exp_hits++;
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("refill_hitcnt", 64'(bus.ic_hit_cnt_o), 64'(exp_hits));

        // reset while waiting on tag 2; the late return must be dropped
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h118;
        step();
        bus.if_req_vld_i = 1'b0; bus.mem2ic_response_i = 4'd2;
        step();
        bus.mem2ic_response_i = '0; #1;
        check_eq("prerst_busy", 64'(bus.icache_busy_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        check_eq("midrst_busy", 64'(bus.icache_busy_o), 64'd0);
        check_eq("midrst_miss", 64'(bus.ic_miss_cnt_o), 64'd0);
        check_eq("midrst_hits", 64'(bus.ic_hit_cnt_o), 64'd0);
        bus.mem2ic_tag_i = 4'd2; bus.mem2ic_data_i = 64'h7777;
        step();
        bus.mem2ic_tag_i = '0; #1;
        check_eq("late_tag_busy", 64'(bus.icache_busy_o), 64'd0);
        bus.if_req_vld_i = 1'b1; bus.if_req_addr_i = 64'h118; #1;
        check_eq("late_tag_nofill", 64'(bus.icache_vld_o), 64'd0);
        step();
        bus.if_req_addr_i = 64'h100; #1;
        check_eq("rst_cleared_line", 64'(bus.icache_vld_o), 64'd0);
        bus.if_req_vld_i = 1'b0; #1;
        check_eq("postrst_miss", 64'(bus.ic_miss_cnt_o), 64'd1);
        check_eq("postrst_cmd", 64'(bus.ic2mem_command_o), 64'd1);
        check_eq("postrst_addr", bus.ic2mem_addr_o, 64'h118);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
